// File: rtl/debounce_multi_pkg.sv
// Shared types and elaboration helpers for the multi-channel debouncer.
// Repeat FSM encodings are kept at their historical values for drop-in compatibility.
package debounce_multi_pkg;

   typedef enum logic [1:0] {
      RPT_IDLE   = 2'd0,
      RPT_DELAY  = 2'd1,
      RPT_REPEAT = 2'd2
   } rpt_state_e;

   function automatic longint unsigned field_max(input int unsigned w);
      return (64'd1 << w) - 64'd1;
   endfunction

   // A terminal count must be non-zero and representable in its counter.
   function automatic bit limit_ok(input longint unsigned v, input int unsigned w);
      return (v >= 64'd1) && (v <= field_max(w));
   endfunction

endpackage

// File: rtl/debounce_multi_chan.sv
// One debounce channel: synchroniser, stability counter, edge pulses and
// hold-to-repeat pulse generator.
module debounce_chan
   import debounce_multi_pkg::*;
#(
   parameter int SYNC_STAGES  = 2,
   parameter int CNT_W        = 17,
   parameter int STABLE_CNT   = 100000,
   parameter int REPEAT_EN    = 1,
   parameter int RPT_W        = 26,
   parameter int REPEAT_DELAY = 50000000,
   parameter int REPEAT_RATE  = 10000000
) (
   input  logic clk,
   input  logic rst,
   input  logic src,
   output logic dst,
   output logic rise,
   output logic fall,
   output logic rpt
);

   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CNT - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   dst_q, dst_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   rpt_q;
   logic                   sync;

   assign sync = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], src};
      cnt_d  = cnt_q;
      dst_d  = dst_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (sync == dst_q) begin
         cnt_d = '0;
      end else if (cnt_q == STABLE_LAST) begin
         dst_d  = sync;
         cnt_d  = '0;
         rise_d = sync;
         fall_d = ~sync;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         cnt_q  <= '0;
         dst_q  <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         dst_q  <= dst_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   if (REPEAT_EN != 0) begin : g_rpt
      localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
      localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

      rpt_state_e       state_q, state_d;
      logic [RPT_W-1:0] tmr_q, tmr_d;
      logic             rpt_d;

      // A release seen this cycle wins over any timer expiry in the same cycle.
      always_comb begin
         state_d = state_q;
         tmr_d   = tmr_q;
         rpt_d   = 1'b0;
         if (fall_q) begin
            state_d = RPT_IDLE;
            tmr_d   = '0;
         end else begin
            unique case (state_q)
               RPT_IDLE: begin
                  if (rise_q) begin
                     rpt_d   = 1'b1;
                     tmr_d   = '0;
                     state_d = RPT_DELAY;
                  end
               end
               RPT_DELAY: begin
                  if (tmr_q == DELAY_LAST) begin
                     rpt_d   = 1'b1;
                     tmr_d   = '0;
                     state_d = RPT_REPEAT;
                  end else begin
                     tmr_d = tmr_q + 1'b1;
                  end
               end
               RPT_REPEAT: begin
                  if (tmr_q == RATE_LAST) begin
                     rpt_d = 1'b1;
                     tmr_d = '0;
                  end else begin
                     tmr_d = tmr_q + 1'b1;
                  end
               end
               default: begin
                  state_d = RPT_IDLE;
                  tmr_d   = '0;
               end
            endcase
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            state_q <= RPT_IDLE;
            tmr_q   <= '0;
            rpt_q   <= 1'b0;
         end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            rpt_q   <= rpt_d;
         end
      end
   end else begin : g_no_rpt
      always_ff @(posedge clk) begin
         if (rst) rpt_q <= 1'b0;
         else     rpt_q <= rise_q;
      end
   end

   assign dst  = dst_q;
   assign rise = rise_q;
   assign fall = fall_q;
   assign rpt  = rpt_q;

endmodule

// File: rtl/debounce_multi.sv
// N independent debounce channels for the stopwatch buttons and switches,
// with elaboration-time range checks on the timing parameters.
module debounce_multi
   import debounce_multi_pkg::*;
#(
   parameter int N            = 4,
   parameter int SYNC_STAGES  = 2,
   parameter int CNT_W        = 17,
   parameter int STABLE_CNT   = 100000,
   parameter int REPEAT_EN    = 1,
   parameter int RPT_W        = 26,
   parameter int REPEAT_DELAY = 50000000,
   parameter int REPEAT_RATE  = 10000000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] src,
   output logic [N-1:0] dst,
   output logic [N-1:0] rise,
   output logic [N-1:0] fall,
   output logic [N-1:0] rpt
);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("debounce_multi: SYNC_STAGES must be at least 2");
   end
   if (!limit_ok(longint'(STABLE_CNT), CNT_W)) begin : g_bad_stable
      $error("debounce_multi: STABLE_CNT must be in 1 .. 2**CNT_W-1");
   end
   if (!limit_ok(longint'(REPEAT_DELAY), RPT_W)) begin : g_bad_delay
      $error("debounce_multi: REPEAT_DELAY must be in 1 .. 2**RPT_W-1");
   end
   if (!limit_ok(longint'(REPEAT_RATE), RPT_W)) begin : g_bad_rate
      $error("debounce_multi: REPEAT_RATE must be in 1 .. 2**RPT_W-1");
   end

   for (genvar i = 0; i < N; i++) begin : g_chan
      debounce_chan #(
         .SYNC_STAGES  (SYNC_STAGES),
         .CNT_W        (CNT_W),
         .STABLE_CNT   (STABLE_CNT),
         .REPEAT_EN    (REPEAT_EN),
         .RPT_W        (RPT_W),
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_RATE  (REPEAT_RATE)
      ) u_chan (
         .clk  (clk),
         .rst  (rst),
         .src  (src[i]),
         .dst  (dst[i]),
         .rise (rise[i]),
         .fall (fall[i]),
         .rpt  (rpt[i])
      );
   end

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi: a per-edge reference model pushes
// expected outputs, a negedge monitor pops and compares them.
module tb_debounce_multi;

   localparam int N      = 2;
   localparam int SYNC   = 2;
   localparam int STABLE = 4;
   localparam int DELAY  = 10;
   localparam int RATE   = 3;
   localparam int MAXE   = 8192;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] src;
   logic [N-1:0] dst, rise, fall, rpt;

   debounce_multi #(
      .N            (N),
      .SYNC_STAGES  (SYNC),
      .CNT_W        (3),
      .STABLE_CNT   (STABLE),
      .REPEAT_EN    (1),
      .RPT_W        (5),
      .REPEAT_DELAY (DELAY),
      .REPEAT_RATE  (RATE)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .src  (src),
      .dst  (dst),
      .rise (rise),
      .fall (fall),
      .rpt  (rpt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [N-1:0] dst;
      logic [N-1:0] rise;
      logic [N-1:0] fall;
      logic [N-1:0] rpt;
   } exp_t;

   exp_t exp_q[$];
   int   exp_edge_q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model state: raw samples per edge plus a few event timestamps.
   int           t = 0;
   logic [N-1:0] samp [0:MAXE];
   bit           rst_e [0:MAXE];
   logic [N-1:0] m_dst = '0;
   logic [N-1:0] m_rise = '0;
   logic [N-1:0] m_fall = '0;
   bit           active [N];
   int           press_t [N];

   function automatic logic sync_seen(input int e, input int c);
      logic [N-1:0] v;
      if (e - SYNC < 1) return 1'b0;
      v = samp[e - SYNC];
      return v[c];
   endfunction

   always @(posedge clk) begin
      exp_t   e;
      logic   sy;
      bit     settled;
      t++;
      rst_e[t] = rst;
      samp[t]  = rst ? '0 : src;
      e = '0;
      if (rst) begin
         m_dst  = '0;
         m_rise = '0;
         m_fall = '0;
         for (int c = 0; c < N; c++) active[c] = 0;
      end else begin
         for (int c = 0; c < N; c++) begin
            // Press pulse one edge after rise, then DELAY later, then every RATE.
            if (m_rise[c]) begin
               active[c]  = 1;
               press_t[c] = t;
               e.rpt[c]   = 1'b1;
            end else if (m_fall[c]) begin
               active[c] = 0;
            end else if (active[c]) begin
               e.rpt[c] = (t >= press_t[c] + DELAY) &&
                          (((t - press_t[c] - DELAY) % RATE) == 0);
            end
            // dst follows sync once sync has disagreed for STABLE consecutive edges.
            sy      = sync_seen(t, c);
            settled = (sy != m_dst[c]);
            for (int j = 1; j < STABLE; j++) begin
               if (t - j < 1 || rst_e[t - j] || sync_seen(t - j, c) == m_dst[c])
                  settled = 0;
            end
            m_rise[c] = settled && sy;
            m_fall[c] = settled && !sy;
            if (settled) m_dst[c] = sy;
         end
      end
      e.dst  = m_dst;
      e.rise = m_rise;
      e.fall = m_fall;
      exp_q.push_back(e);
      exp_edge_q.push_back(t);
   end

   always @(negedge clk) begin
      exp_t exp_v;
      exp_t got;
      int   ed;
      if (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         ed    = exp_edge_q.pop_front();
         got   = {dst, rise, fall, rpt};
         total++;
         if (got !== exp_v) begin
            bad++;
            $display("FAIL scoreboard edge %0d: got dst=%b rise=%b fall=%b rpt=%b, expected dst=%b rise=%b fall=%b rpt=%b",
                     ed, got.dst, got.rise, got.fall, got.rpt,
                     exp_v.dst, exp_v.rise, exp_v.fall, exp_v.rpt);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic check_dst(input string name, input logic [N-1:0] want);
      total++;
      if (dst !== want) begin
         bad++;
         $display("FAIL %s: dst=%b expected %b", name, dst, want);
      end
   endtask

   int hold [N];

   initial begin
      rst = 1'b1;
      src = 2'b11;
      // Held through reset release: counts as a fresh press.
      cyc(3);
      rst = 1'b0;
      cyc(12);
      check_dst("held_through_reset", 2'b11);

      // Clean press and release on channel 0.
      src = 2'b10;
      cyc(10);
      check_dst("ch0_released", 2'b10);
      src = 2'b11;
      cyc(10);
      check_dst("ch0_pressed", 2'b11);
      src = 2'b10;
      cyc(10);

      // Bounce on channel 0 before settling high.
      foreach (hold[k]) hold[k] = 0;
      src[0] = 1'b1; cyc(1);
      src[0] = 1'b0; cyc(1);
      src[0] = 1'b1; cyc(1);
      src[0] = 1'b0; cyc(1);
      src[0] = 1'b1; cyc(12);
      check_dst("bounce_settled", 2'b11);

      // Long hold on channel 1 to exercise auto-repeat, then release.
      src = 2'b00;
      cyc(12);
      src[1] = 1'b1;
      cyc(40);
      src[1] = 1'b0;
      cyc(15);

      // Simultaneous press, channel 0 glitches back after two cycles.
      src = 2'b11;
      cyc(2);
      src[0] = 1'b0;
      cyc(30);
      check_dst("glitch_reject", 2'b10);
      src = 2'b00;
      cyc(12);

      // Reset in the middle of repeating with the input still held.
      src[1] = 1'b1;
      cyc(25);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      cyc(30);
      check_dst("post_reset_rise", 2'b10);

      // Random bursts with occasional resets.
      for (int c = 0; c < N; c++) hold[c] = $urandom_range(1, 9);
      for (int i = 0; i < 2000; i++) begin
         for (int c = 0; c < N; c++) begin
            hold[c]--;
            if (hold[c] <= 0) begin
               src[c]  = ~src[c];
               hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 40)
                                                      : $urandom_range(1, 6);
            end
         end
         rst = ($urandom_range(0, 299) == 0);
         cyc(1);
      end
      rst = 1'b0;
      src = '0;
      cyc(20);
      check_dst("final_idle", 2'b00);

      @(negedge clk);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: pending=%0d expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
